mux_select_arbiter: RTL and testbench

- Control stage directly upstream of the 2:1 multiplexer datapath.
- Arbitrates between two valid/ready sources, A and B, and drives the multiplexer select bit S.
- Presents one handshaked output stream. Data itself flows through the external 2:1 mux; this block owns select, valid and ready only.
- Round-robin arbitration with a bounded burst length per grant.

---
 rtl/mux_select_arbiter.sv | 65 ++++++
 tb/tb_mux_select_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter: round-robin valid/ready arbiter with bounded bursts driving a 2:1 mux select; MUX_ARB_STATS_EN adds saturating transfer counters
module mux_select_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic A_valid,
  output logic A_ready,
  input  logic B_valid,
  output logic B_ready,
  output logic S,
  output logic out_valid,
  input  logic out_ready
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [15:0] xfer_cnt_A,
  output logic [15:0] xfer_cnt_B
`endif
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
  state_t state, nxt;
  logic last_b;
  logic [CNT_W-1:0] cnt;
  logic grant, cur_valid, oth_valid, xfer, leave;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      S <= 1'b0;
      cnt <= '0;
      last_b <= 1'b1;
    end else begin
      state <= nxt;
      S <= nxt == GRANT_A ? 1'b0 : nxt == GRANT_B ? 1'b1 : S;
      cnt <= leave ? '0 : xfer ? cnt + CNT_W'(1) : cnt;
      if (leave) last_b <= state == GRANT_B;
    end
  end
  always_comb begin
    nxt = state == IDLE ? (A_valid & (~B_valid | last_b) ? GRANT_A : B_valid ? GRANT_B : IDLE)
        : leave ? (oth_valid ? (state == GRANT_A ? GRANT_B : GRANT_A) : IDLE)
        : state;
  end
  always_comb begin
    grant = state != IDLE;
    cur_valid = state == GRANT_B ? B_valid : A_valid;
    oth_valid = state == GRANT_B ? A_valid : B_valid;
    out_valid = ~rst & grant & cur_valid;
    A_ready = ~rst & (state == GRANT_A) & out_ready;
    B_ready = ~rst & (state == GRANT_B) & out_ready;
    xfer = out_valid & out_ready;
    leave = grant & (~cur_valid | (xfer & (cnt == CNT_W'(MAX_BURST - 1))));
  end
`ifdef MUX_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_A <= '0;
      xfer_cnt_B <= '0;
    end else begin
      if (xfer & (state == GRANT_A) & ~&xfer_cnt_A) xfer_cnt_A <= xfer_cnt_A + 16'd1;
      if (xfer & (state == GRANT_B) & ~&xfer_cnt_B) xfer_cnt_B <= xfer_cnt_B + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mux_select_arbiter.sv
// tb_mux_select_arbiter: randomized and directed checks of two arbiter instances (MAX_BURST 4 and 1) against a behavioural model
module tb_mux_select_arbiter;
  logic clk = 0, rst = 1, av = 0, bv = 0, ordy = 0;
  logic [1:0] ov, a_rdy, b_rdy, sv;
`ifdef MUX_ARB_STATS_EN
  logic [15:0] ca[2], cb[2];
`endif
  int errs = 0, checks = 0;
  int owner[2], burst[2], mca[2], mcb[2];
  bit lastb[2], ms[2];
  bit acc_a, acc_b;
  always #5 clk = ~clk;
  mux_select_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .A_valid(av), .A_ready(a_rdy[0]), .B_valid(bv), .B_ready(b_rdy[0]),
    .S(sv[0]), .out_valid(ov[0]), .out_ready(ordy)
`ifdef MUX_ARB_STATS_EN
    , .xfer_cnt_A(ca[0]), .xfer_cnt_B(cb[0])
`endif
  );
  mux_select_arbiter #(.MAX_BURST(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .A_valid(av), .A_ready(a_rdy[1]), .B_valid(bv), .B_ready(b_rdy[1]),
    .S(sv[1]), .out_valid(ov[1]), .out_ready(ordy)
`ifdef MUX_ARB_STATS_EN
    , .xfer_cnt_A(ca[1]), .xfer_cnt_B(cb[1])
`endif
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic model_step(input int i);
    int mb;
    bit cv, oth, x;
    mb = i == 0 ? 4 : 1;
    if (rst) begin
      owner[i] = 0; burst[i] = 0; lastb[i] = 1; ms[i] = 0; mca[i] = 0; mcb[i] = 0;
      return;
    end
    if (owner[i] == 0) begin
      if (av && bv) owner[i] = lastb[i] ? 1 : 2;
      else if (av) owner[i] = 1;
      else if (bv) owner[i] = 2;
    end else begin
      cv = owner[i] == 1 ? av : bv;
      oth = owner[i] == 1 ? bv : av;
      x = cv && ordy;
      if (x) begin
        burst[i]++;
        if (owner[i] == 1 && mca[i] < 65535) mca[i]++;
        if (owner[i] == 2 && mcb[i] < 65535) mcb[i]++;
      end
      if (!cv || (x && burst[i] == mb)) begin
        lastb[i] = owner[i] == 2;
        burst[i] = 0;
        owner[i] = oth ? 3 - owner[i] : 0;
      end
    end
    if (owner[i] != 0) ms[i] = owner[i] == 2;
  endtask
  task automatic cycle();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("out_valid%0d", i), ov[i], !rst && (owner[i] == 1 ? av : owner[i] == 2 ? bv : 1'b0));
      chk($sformatf("A_ready%0d", i), a_rdy[i], !rst && owner[i] == 1 && ordy);
      chk($sformatf("B_ready%0d", i), b_rdy[i], !rst && owner[i] == 2 && ordy);
      chk($sformatf("S%0d", i), sv[i], ms[i]);
`ifdef MUX_ARB_STATS_EN
      chk($sformatf("xfer_cnt_A%0d", i), ca[i], mca[i]);
      chk($sformatf("xfer_cnt_B%0d", i), cb[i], mcb[i]);
`endif
    end
    acc_a = av && a_rdy[0];
    acc_b = bv && b_rdy[0];
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1; av = 0; bv = 0; ordy = 0;
    cycle();
    rst = 0;
  endtask
  initial begin
    bit [6:0] la0, la1;
    int ls[13];
    la0 = 7'b1011110;
    la1 = 7'b0101010;
    ls = '{0, 0, 2, 0, 2, 1, 3, 1, 3, 0, 2, 0, 2};
    @(negedge clk);
    do_reset();
    #1;
    chk("reset_state", {ov, a_rdy, b_rdy, sv}, 0);
    av = 1; bv = 0; ordy = 1;
    for (int k = 0; k < 7; k++) begin
      #1 chk($sformatf("lit_a_only_k%0d", k), a_rdy, {la1[k], la0[k]});
      cycle();
    end
    do_reset();
    av = 1; bv = 1; ordy = 1;
    for (int k = 0; k < 13; k++) begin
      #1 chk($sformatf("lit_both_S_k%0d", k), sv, ls[k]);
      cycle();
    end
    do_reset();
    av = 0; bv = 1; ordy = 0;
    for (int k = 0; k < 6; k++) begin
      #1 if (k > 0) chk($sformatf("lit_stall_k%0d", k), {ov[0], sv[0], b_rdy[0], a_rdy[0]}, 4'b1100);
      cycle();
    end
    ordy = 1;
    repeat (6) cycle();
    do_reset();
    av = 1; bv = 0; ordy = 1;
    cycle();
    cycle();
    rst = 1;
    #1 chk("lit_mid_reset", {ov[0], a_rdy[0], b_rdy[0]}, 0);
    cycle();
    rst = 0; bv = 1;
    #1 chk("lit_post_reset_idle", {ov[0], sv[0]}, 0);
    cycle();
    #1 chk("lit_a_first", {a_rdy[0], b_rdy[0], sv[0]}, 3'b100);
    cycle();
    do_reset();
    repeat (4000) begin
      if (!av || acc_a) av = $urandom_range(0, 3) != 0;
      if (!bv || acc_b) bv = $urandom_range(0, 2) != 0;
      ordy = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
      cycle();
    end
    rst = 0;
`ifdef MUX_ARB_STATS_EN
    do_reset();
    av = 1; bv = 0; ordy = 1;
    repeat (81930) cycle();
    #1 chk("lit_sat_A", ca[0], 16'hFFFF);
    chk("lit_sat_B", cb[0], 16'h0000);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
